// File: rtl/fft_ctrl_if.sv
// Handshake and address bus between the FFT sequencer and its sample RAM,
// butterfly pipeline and twiddle ROM.
interface fft_ctrl_if #(
  parameter int LOG2N = 10
);
  localparam int SW = $clog2(LOG2N);

  logic             start;
  logic             busy;
  logic             done;
  logic [SW-1:0]    stage;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addra;
  logic [LOG2N-1:0] rd_addrb;
  logic [LOG2N-2:0] tw_addr;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addra;
  logic [LOG2N-1:0] wr_addrb;

  modport master (
    input  start,
    output busy, done, stage,
    output rd_en, rd_addra, rd_addrb, tw_addr,
    output wr_en, wr_addra, wr_addrb
  );

  modport slave (
    output start,
    input  busy, done, stage,
    input  rd_en, rd_addra, rd_addrb, tw_addr,
    input  wr_en, wr_addra, wr_addrb
  );
endinterface

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: walks LOG2N stages of N/2 butterflies,
// issues read/twiddle addresses and replays them as write-backs BF_LATENCY later.
module fft_ctrl #(
  parameter int LOG2N      = 10,
  parameter int BF_LATENCY = 6
) (
  input  logic          clk,
  input  logic          rst,
  fft_ctrl_if.master    bus
);
  localparam int SW = $clog2(LOG2N);
  localparam int KW = LOG2N - 1;
  localparam int DW = $clog2(BF_LATENCY + 1);

  localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(BF_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  typedef struct packed {
    logic             vld;
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
  } wr_slot_t;

  state_t           state_reg, state_next;
  logic [KW-1:0]    k_reg, k_next;
  logic [SW-1:0]    stage_reg, stage_next;
  logic [DW-1:0]    drain_reg, drain_next;

  logic             busy_reg, done_reg, rd_en_reg;
  logic [SW-1:0]    stage_out_reg;
  logic [LOG2N-1:0] rd_addra_reg, rd_addrb_reg;
  logic [KW-1:0]    tw_addr_reg;

  logic [LOG2N-1:0] span_c, pos_c, grp_c, addra_c, addrb_c, tw_full_c;

  wr_slot_t         pipe_tap [BF_LATENCY+1];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      stage_reg <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      stage_reg <= stage_next;
      drain_reg <= drain_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    stage_next = stage_reg;
    drain_next = drain_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          stage_next = '0;
          k_next     = '0;
        end
      end
      RUN: begin
        k_next = k_reg + 1'b1;
        if (k_reg == K_LAST) begin
          state_next = DRAIN;
          drain_next = '0;
        end
      end
      DRAIN: begin
        // Hold reads off until every write of this stage has left the pipe.
        drain_next = drain_reg + 1'b1;
        if (drain_reg == D_LAST) begin
          if (stage_reg == S_LAST) begin
            state_next = FINISH;
          end else begin
            state_next = RUN;
            stage_next = stage_reg + 1'b1;
            k_next     = '0;
          end
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------- address generation
  always_comb begin
    span_c    = LOG2N'(1) << stage_reg;
    pos_c     = {1'b0, k_reg} & (span_c - 1'b1);
    grp_c     = {1'b0, k_reg} >> stage_reg;
    // Two shifts avoid overflowing the stage width when computing 2^(s+1).
    addra_c   = ((grp_c << stage_reg) << 1) | pos_c;
    addrb_c   = addra_c + span_c;
    tw_full_c = pos_c << (S_LAST - stage_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      rd_en_reg     <= 1'b0;
      stage_out_reg <= '0;
      rd_addra_reg  <= '0;
      rd_addrb_reg  <= '0;
      tw_addr_reg   <= '0;
    end else begin
      busy_reg  <= (state_reg != IDLE);
      done_reg  <= (state_reg == FINISH);
      rd_en_reg <= (state_reg == RUN);
      if (state_reg == RUN) begin
        stage_out_reg <= stage_reg;
        rd_addra_reg  <= addra_c;
        rd_addrb_reg  <= addrb_c;
        tw_addr_reg   <= tw_full_c[KW-1:0];
      end
    end
  end

  // ------------------------------------------------------ write-back pipe
  assign pipe_tap[0] = '{vld: rd_en_reg, a: rd_addra_reg, b: rd_addrb_reg};

  generate
    for (genvar gi = 0; gi < BF_LATENCY; gi++) begin : g_wr_pipe
      wr_slot_t slot_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          slot_reg <= '0;
        end else begin
          slot_reg <= pipe_tap[gi];
        end
      end
      assign pipe_tap[gi+1] = slot_reg;
    end
  endgenerate

  // -------------------------------------------------------------- outputs
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.stage    = stage_out_reg;
  assign bus.rd_en    = rd_en_reg;
  assign bus.rd_addra = rd_addra_reg;
  assign bus.rd_addrb = rd_addrb_reg;
  assign bus.tw_addr  = tw_addr_reg;
  assign bus.wr_en    = pipe_tap[BF_LATENCY].vld;
  assign bus.wr_addra = pipe_tap[BF_LATENCY].a;
  assign bus.wr_addrb = pipe_tap[BF_LATENCY].b;

endmodule

// File: tb/tb_fft_ctrl.sv
// Scoreboard bench for fft_ctrl at LOG2N=3, BF_LATENCY=6: expected read, write,
// done and busy events are queued at stimulus time and matched by a monitor.
module tb_fft_ctrl;
  localparam int LOG2N = 3;
  localparam int BFL   = 6;
  localparam int BIG   = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  fft_ctrl_if #(.LOG2N(LOG2N)) bus_if ();

  fft_ctrl #(.LOG2N(LOG2N), .BF_LATENCY(BFL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
    int stg;
  } xact_t;

  xact_t rd_q[$];
  xact_t wr_q[$];
  int    done_q[$];
  bit    exp_busy [1024];
  xact_t mon_rd, mon_wr;
  int    mon_done;

  // Hand-derived schedule for one transform, offsets from the start-sampling edge.
  int tab_off [12] = '{1, 2, 3, 4, 11, 12, 13, 14, 21, 22, 23, 24};
  int tab_a   [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int tab_b   [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int tab_tw  [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  int tab_stg [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Queue everything a transform started at edge b0 should produce before cycle cut.
  task automatic push_run(input int b0, input int cut);
    xact_t x;
    for (int i = 0; i < 12; i++) begin
      x.a = tab_a[i]; x.b = tab_b[i]; x.tw = tab_tw[i]; x.stg = tab_stg[i];
      x.cyc = b0 + tab_off[i];
      if (x.cyc < cut) rd_q.push_back(x);
      x.cyc = b0 + tab_off[i] + BFL;
      if (x.cyc < cut) wr_q.push_back(x);
    end
    if (b0 + 31 < cut) done_q.push_back(b0 + 31);
    for (int c = b0 + 1; c <= b0 + 31 && c < cut; c++) exp_busy[c] = 1'b1;
    $display("run issued: start edge %0d, cut %0d", b0, cut);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},     int'(bus_if.busy),     0);
    chk({tag, "_done"},     int'(bus_if.done),     0);
    chk({tag, "_stage"},    int'(bus_if.stage),    0);
    chk({tag, "_rd_en"},    int'(bus_if.rd_en),    0);
    chk({tag, "_rd_addra"}, int'(bus_if.rd_addra), 0);
    chk({tag, "_rd_addrb"}, int'(bus_if.rd_addrb), 0);
    chk({tag, "_tw_addr"},  int'(bus_if.tw_addr),  0);
    chk({tag, "_wr_en"},    int'(bus_if.wr_en),    0);
    chk({tag, "_wr_addra"}, int'(bus_if.wr_addra), 0);
    chk({tag, "_wr_addrb"}, int'(bus_if.wr_addrb), 0);
  endtask

  task automatic pulse_start(input int edge_n);
    wait_to(edge_n - 1);
    bus_if.start = 1'b1;
    wait_to(edge_n);
    bus_if.start = 1'b0;
  endtask

  // Monitor: match every strobe against the scoreboard, flag missed events.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", int'(bus_if.busy), int'(exp_busy[cyc]));

      if (bus_if.rd_en === 1'b1) begin
        chk("rd_expected", int'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) begin
          mon_rd = rd_q.pop_front();
          chk("rd_cycle", cyc, mon_rd.cyc);
          chk("rd_addra", int'(bus_if.rd_addra), mon_rd.a);
          chk("rd_addrb", int'(bus_if.rd_addrb), mon_rd.b);
          chk("tw_addr",  int'(bus_if.tw_addr),  mon_rd.tw);
          chk("stage",    int'(bus_if.stage),    mon_rd.stg);
          $display("rd  cyc %0d a %0d b %0d tw %0d stage %0d", cyc,
                   bus_if.rd_addra, bus_if.rd_addrb, bus_if.tw_addr, bus_if.stage);
        end
      end else if (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
        chk("rd_en_at_expected_cycle", int'(bus_if.rd_en), 1);
        void'(rd_q.pop_front());
      end

      if (bus_if.wr_en === 1'b1) begin
        chk("wr_expected", int'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          mon_wr = wr_q.pop_front();
          chk("wr_cycle", cyc, mon_wr.cyc);
          chk("wr_addra", int'(bus_if.wr_addra), mon_wr.a);
          chk("wr_addrb", int'(bus_if.wr_addrb), mon_wr.b);
          $display("wr  cyc %0d a %0d b %0d", cyc, bus_if.wr_addra, bus_if.wr_addrb);
        end
      end else if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
        chk("wr_en_at_expected_cycle", int'(bus_if.wr_en), 1);
        void'(wr_q.pop_front());
      end

      if (bus_if.done === 1'b1) begin
        chk("done_expected", int'(done_q.size() != 0), 1);
        if (done_q.size() != 0) begin
          mon_done = done_q.pop_front();
          chk("done_cycle", cyc, mon_done);
          $display("done cyc %0d", cyc);
        end
      end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
        chk("done_at_expected_cycle", int'(bus_if.done), 1);
        void'(done_q.pop_front());
      end
    end
  end

  initial begin
    #40000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    bus_if.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    // Start asserted with reset: reset must win.
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    mon_en = 1'b1;

    // Single transform with start pulses while busy (must be ignored).
    b0 = cyc + 2;
    push_run(b0, BIG);
    pulse_start(b0);
    pulse_start(b0 + 5);
    pulse_start(b0 + 15);
    wait_to(b0 + 40);

    // Reset mid-transform, then a clean transform afterwards.
    b0 = cyc + 2;
    push_run(b0, b0 + 12);
    pulse_start(b0);
    wait_to(b0 + 11);
    rst = 1'b1;
    wait_to(b0 + 12);
    rst = 1'b0;
    for (int c = b0 + 13; c <= b0 + 19; c++) begin
      wait_to(c);
      check_zero("post_rst");
    end
    push_run(b0 + 20, BIG);
    pulse_start(b0 + 20);
    wait_to(b0 + 60);

    // Start held high: second transform follows done by two cycles.
    b0 = cyc + 2;
    push_run(b0, BIG);
    push_run(b0 + 32, BIG);
    wait_to(b0 - 1);
    bus_if.start = 1'b1;
    wait_to(b0 + 32);
    bus_if.start = 1'b0;
    wait_to(b0 + 72);

    chk("rd_q_left",   rd_q.size(),   0);
    chk("wr_q_left",   wr_q.size(),   0);
    chk("done_q_left", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
